data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_if.sv | 31 +++
 rtl/data_memory_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// ============================================================================
// Module      : data_memory_ctrl_if
// Description : Request/response bus between a load/store master and
//               data_memory_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_memory_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        write_en;
    logic [2:0]  dm_control;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        resp_err;

    modport master (
        output req_valid, write_en, dm_control, address, write_data,
        input  req_ready, resp_valid, read_data, resp_err
    );

    modport slave (
        input  req_valid, write_en, dm_control, address, write_data,
        output req_ready, resp_valid, read_data, resp_err
    );
endinterface

`default_nettype wire

// File: rtl/data_memory_ctrl.sv
// ============================================================================
// Module      : data_memory_ctrl
// Description : Byte-addressed data memory with byte/half/word load/store,
//               sign/zero extension and range/legality checking.
//               Optional macro DATA_MEMORY_CTRL_MISALIGN_SPLIT_EN enables
//               word-crossing accesses as two beats (IDLE->SPLIT->RESP).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 4096,
    parameter int INIT_ZERO   = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    data_memory_ctrl_if.slave bus
);

    localparam int         c_AW        = $clog2(DEPTH_BYTES);
    localparam logic [7:0] c_INIT_BYTE = (INIT_ZERO != 0) ? 8'h00 : 8'hxx;

`ifdef DATA_MEMORY_CTRL_MISALIGN_SPLIT_EN
    localparam logic c_SPLIT_EN = 1'b1;
`else
    localparam logic c_SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPLIT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Contents survive reset, so the array lives outside the reset domain.
    logic [7:0] r_mem [DEPTH_BYTES] = '{default: c_INIT_BYTE};

    logic [c_AW-1:0] r_addr;
    logic [2:0]      r_size;
    logic [2:0]      r_ctrl;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic [31:0]     r_raw;
    logic            r_err;
    logic [31:0]     r_rdata;

    logic [2:0]      w_size;
    logic            w_illegal;
    logic [32:0]     w_last;
    logic            w_oob;
    logic [2:0]      w_lo_end;
    logic            w_cross;
    logic            w_err;
    logic            w_split;
    logic            w_fire;

    logic [3:0]      w_lo_lane;
    logic [3:0]      w_hi_lane;
    logic [c_AW-1:0] w_idx_new [4];
    logic [c_AW-1:0] w_idx_old [4];
    logic [7:0]      w_rd_new  [4];
    logic [7:0]      w_rd_old  [4];
    logic [31:0]     w_ld_raw;

    logic [3:0]      w_wr_en;
    logic [c_AW-1:0] w_wr_idx  [4];
    logic [7:0]      w_wr_byte [4];

    function automatic logic [31:0] f_extend(input logic [2:0] ctrl, input logic [31:0] raw);
        logic [31:0] v;
        case (ctrl)
            3'b000:  v = {{24{raw[7]}}, raw[7:0]};
            3'b001:  v = {{16{raw[15]}}, raw[15:0]};
            3'b100:  v = {24'd0, raw[7:0]};
            3'b101:  v = {16'd0, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    // Request decode
    always_comb begin
        w_size    = 3'd1;
        w_illegal = 1'b0;
        case (bus.dm_control)
            3'b000:  w_size = 3'd1;
            3'b001:  w_size = 3'd2;
            3'b010:  w_size = 3'd4;
            3'b100: begin
                w_size    = 3'd1;
                w_illegal = bus.write_en;
            end
            3'b101: begin
                w_size    = 3'd2;
                w_illegal = bus.write_en;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Range check in 33 bits so an access near 0xFFFFFFFF cannot wrap to a legal one.
    assign w_last   = {1'b0, bus.address} + 33'(w_size) - 33'd1;
    assign w_oob    = (w_last >= 33'(DEPTH_BYTES));
    assign w_lo_end = {1'b0, bus.address[1:0]} + (w_size - 3'd1);
    assign w_cross  = w_lo_end[2];
    assign w_err    = w_illegal | w_oob | (w_cross & ~c_SPLIT_EN);
    assign w_split  = w_cross & c_SPLIT_EN & ~w_illegal & ~w_oob;
    assign w_fire   = bus.req_valid & bus.req_ready;

    // Lane k is byte offset k from the request address; lo lanes sit in the
    // first word, hi lanes spill into the following word.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [2:0] w_pos_new;
        logic [2:0] w_pos_old;
        assign w_pos_new    = {1'b0, bus.address[1:0]} + 3'(k);
        assign w_pos_old    = {1'b0, r_addr[1:0]} + 3'(k);
        assign w_lo_lane[k] = (3'(k) < w_size) && !w_pos_new[2];
        assign w_hi_lane[k] = (3'(k) < r_size) && w_pos_old[2];
        assign w_idx_new[k] = bus.address[c_AW-1:0] + c_AW'(k);
        assign w_idx_old[k] = r_addr + c_AW'(k);
        assign w_rd_new[k]  = r_mem[w_idx_new[k]];
        assign w_rd_old[k]  = r_mem[w_idx_old[k]];
    end

    always_comb begin
        w_ld_raw = '0;
        for (int k = 0; k < 4; k++) begin
            if (r_state == S_SPLIT) begin
                w_ld_raw[8*k +: 8] = w_hi_lane[k] ? w_rd_old[k] : r_raw[8*k +: 8];
            end else if (w_lo_lane[k]) begin
                w_ld_raw[8*k +: 8] = w_rd_new[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_wr_en[k]   = 1'b0;
            w_wr_idx[k]  = w_idx_new[k];
            w_wr_byte[k] = bus.write_data[8*k +: 8];
            if (r_state == S_SPLIT) begin
                w_wr_en[k]   = r_we & w_hi_lane[k];
                w_wr_idx[k]  = w_idx_old[k];
                w_wr_byte[k] = r_wdata[8*k +: 8];
            end else begin
                w_wr_en[k] = w_fire & bus.write_en & ~w_err & w_lo_lane[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_wr_en[k]) begin
                r_mem[w_wr_idx[k]] <= w_wr_byte[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fire) begin
                    w_state_nxt = w_split ? S_SPLIT : S_RESP;
                end
            end
            S_SPLIT: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_ctrl  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_raw   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_fire) begin
            r_addr  <= bus.address[c_AW-1:0];
            r_size  <= w_size;
            r_ctrl  <= bus.dm_control;
            r_we    <= bus.write_en & ~w_err;
            r_wdata <= bus.write_data;
            r_raw   <= w_ld_raw;
            r_err   <= w_err;
            if (!w_split) begin
                r_rdata <= (w_err | bus.write_en) ? '0 : f_extend(bus.dm_control, w_ld_raw);
            end
        end else if (r_state == S_SPLIT) begin
            r_err   <= 1'b0;
            r_rdata <= r_we ? '0 : f_extend(r_ctrl, w_ld_raw);
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) & ~rst;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_err   = (r_state == S_RESP) & r_err;
    assign bus.read_data  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
// ============================================================================
// Module      : tb_data_memory_ctrl
// Description : Directed, table-driven self-checking bench for data_memory_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_ctrl;

    localparam int c_DEPTH = 64;
    localparam logic [2:0] c_B = 3'b000, c_H = 3'b001, c_W = 3'b010,
                           c_BU = 3'b100, c_HU = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    data_memory_ctrl_if bus();

    data_memory_ctrl #(
        .DEPTH_BYTES (c_DEPTH),
        .INIT_ZERO   (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd,
                          output logic er, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_ready_timeout: got 0, expected 1");
        end
        bus.req_valid  = 1'b1;
        bus.write_en   = we;
        bus.dm_control = ctrl;
        bus.address    = addr;
        bus.write_data = wdata;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.address    = 32'hFFFF_FFF0;
        bus.write_data = 32'h5A5A_5A5A;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.read_data;
        er = bus.resp_err;
    endtask

    task automatic run_one(input string name, input logic we, input logic [2:0] ctrl,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(we, ctrl, addr, wdata, rd, er, lat);
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".err"}, {31'd0, er}, {31'd0, exp_err});
        if (!we || exp_err) begin
            check({name, ".data"}, rd, exp_rd);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = name; v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.write_en   = 1'b0;
        bus.dm_control = 3'b000;
        bus.address    = '0;
        bus.write_data = '0;

        add("lw30_init", 0, c_W,  32'h30, 0,            32'h0000_0000, 0, 1);
        add("sw10",      1, c_W,  32'h10, 32'hDEADBEEF, 32'h0,         0, 1);
        add("lw10",      0, c_W,  32'h10, 0,            32'hDEADBEEF,  0, 1);
        add("sw20",      1, c_W,  32'h20, 32'hA1B2C3D4, 32'h0,         0, 1);
        add("sb21",      1, c_B,  32'h21, 32'hFFFFFF80, 32'h0,         0, 1);
        add("lb21",      0, c_B,  32'h21, 0,            32'hFFFFFF80,  0, 1);
        add("lbu21",     0, c_BU, 32'h21, 0,            32'h00000080,  0, 1);
        add("lbu20",     0, c_BU, 32'h20, 0,            32'h000000D4,  0, 1);
        add("lb22",      0, c_B,  32'h22, 0,            32'hFFFFFFB2,  0, 1);
        add("lw20",      0, c_W,  32'h20, 0,            32'hA1B280D4,  0, 1);
        add("lh22",      0, c_H,  32'h22, 0,            32'hFFFFA1B2,  0, 1);
        add("lhu20",     0, c_HU, 32'h20, 0,            32'h000080D4,  0, 1);
        add("lh21",      0, c_H,  32'h21, 0,            32'hFFFFB280,  0, 1);
        add("sh12",      1, c_H,  32'h12, 32'h00001234, 32'h0,         0, 1);
        add("lw10b",     0, c_W,  32'h10, 0,            32'h1234BEEF,  0, 1);
        add("sw3c",      1, c_W,  32'h3C, 32'h55667788, 32'h0,         0, 1);
        add("lw3e_oob",  0, c_W,  32'h3E, 0,            32'h0,         1, 1);
        add("sw3e_oob",  1, c_W,  32'h3E, 32'h0BADF00D, 32'h0,         1, 1);
        add("lhu3e",     0, c_HU, 32'h3E, 0,            32'h00005566,  0, 1);
        add("lb3f",      0, c_B,  32'h3F, 0,            32'h00000055,  0, 1);
        add("lb40_oob",  0, c_B,  32'h40, 0,            32'h0,         1, 1);
        add("lw_top",    0, c_W,  32'hFFFFFFFC, 0,      32'h0,         1, 1);
        add("lw_alias",  0, c_W,  32'h80000010, 0,      32'h0,         1, 1);
        add("ill011",    0, 3'b011, 32'h10, 0,          32'h0,         1, 1);
        add("ill_stbu",  1, c_BU, 32'h10, 32'hFFFFFFFF, 32'h0,         1, 1);
        add("ill110",    1, 3'b110, 32'h10, 32'h0,      32'h0,         1, 1);
        add("ill111",    0, 3'b111, 32'h10, 0,          32'h0,         1, 1);
        add("lw10c",     0, c_W,  32'h10, 0,            32'h1234BEEF,  0, 1);

        // Reset state
        #2;
        check("rst.ready",  {31'd0, bus.req_ready},  32'd0);
        check("rst.valid",  {31'd0, bus.resp_valid}, 32'd0);
        check("rst.err",    {31'd0, bus.resp_err},   32'd0);
        check("rst.rdata",  bus.read_data,           32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel.ready",  {31'd0, bus.req_ready},  32'd1);

        foreach (vecs[i]) begin
            run_one(vecs[i].name, vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Outputs between responses: data holds, error stays low
        @(posedge clk);
        #1;
        check("hold.valid", {31'd0, bus.resp_valid}, 32'd0);
        check("hold.err",   {31'd0, bus.resp_err},   32'd0);
        check("hold.rdata", bus.read_data,           32'h1234BEEF);

        // Continuous illegal requests: one error response every two cycles
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.write_en   = 1'b1;
        bus.dm_control = 3'b011;
        bus.address    = 32'h10;
        bus.write_data = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b.valid%0d", i), {31'd0, bus.resp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b.err%0d", i),   {31'd0, bus.resp_err},   (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus.req_valid = 1'b0;
        run_one("b2b.mem", 0, c_W, 32'h10, 0, 32'h1234BEEF, 0, 1);

        // Word-crossing store
        run_one("sw0", 1, c_W, 32'h0, 32'h03020100, 32'h0, 0, 1);
        run_one("sw4", 1, c_W, 32'h4, 32'h07060504, 32'h0, 0, 1);
`ifdef DATA_MEMORY_CTRL_MISALIGN_SPLIT_EN
        run_one("sw3_split",  1, c_W,  32'h3, 32'h11223344, 32'h0,        0, 2);
        run_one("lw3_split",  0, c_W,  32'h3, 0,            32'h11223344, 0, 2);
        run_one("lh3_split",  0, c_H,  32'h3, 0,            32'h00003344, 0, 2);
        run_one("lbu7",       0, c_BU, 32'h7, 0,            32'h00000007, 0, 1);
        run_one("lbu2",       0, c_BU, 32'h2, 0,            32'h00000002, 0, 1);
`else
        run_one("sw3_cross",  1, c_W,  32'h3, 32'h11223344, 32'h0,        1, 1);
        run_one("lh3_cross",  0, c_H,  32'h3, 0,            32'h0,        1, 1);
        run_one("lw0_keep",   0, c_W,  32'h0, 0,            32'h03020100, 0, 1);
        run_one("lw4_keep",   0, c_W,  32'h4, 0,            32'h07060504, 0, 1);
`endif

        // Reset while a response is pending
        begin
            logic [31:0] rd;
            logic        er;
            int          lat;
            do_req(0, c_W, 32'h10, 0, rd, er, lat);
            check("rresp.pre", rd, 32'h1234BEEF);
            rst = 1'b1;
            #1;
            check("rresp.valid", {31'd0, bus.resp_valid}, 32'd0);
            check("rresp.err",   {31'd0, bus.resp_err},   32'd0);
            check("rresp.rdata", bus.read_data,           32'd0);
            check("rresp.ready", {31'd0, bus.req_ready},  32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            check("rresp.ready_rel", {31'd0, bus.req_ready}, 32'd1);
            run_one("rresp.mem", 0, c_W, 32'h10, 0, 32'h1234BEEF, 0, 1);
        end

`ifdef DATA_MEMORY_CTRL_MISALIGN_SPLIT_EN
        // Reset in the middle of a split store: first beat sticks, second is dropped
        run_one("rs.sw0", 1, c_W, 32'h0, 32'h03020100, 32'h0, 0, 1);
        run_one("rs.sw4", 1, c_W, 32'h4, 32'h07060504, 32'h0, 0, 1);
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.write_en   = 1'b1;
            bus.dm_control = c_W;
            bus.address    = 32'h3;
            bus.write_data = 32'hAABBCCDD;
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            if (bus.resp_valid) seen++;
            #2;
            rst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                if (bus.resp_valid) seen++;
            end
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen++;
            check("rs.no_resp", 32'(seen), 32'd0);
            check("rs.ready",   {31'd0, bus.req_ready}, 32'd1);
        end
        run_one("rs.lbu3", 0, c_BU, 32'h3, 0, 32'h000000DD, 0, 1);
        run_one("rs.lw4",  0, c_W,  32'h4, 0, 32'h07060504, 0, 1);
        run_one("rs.lw0",  0, c_W,  32'h0, 0, 32'hDD020100, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
